// File: rtl/rr_arb_hold_pkg.sv
// Shared definitions for the round-robin hold arbiter slice.
package rr_arb_hold_pkg;

  typedef enum logic {
    GRANT_PULSE = 1'b0,
    GRANT_HOLD  = 1'b1
  } grant_mode_e;

endpackage

// File: rtl/arb_ffs_lsb.sv
// Lowest-set-bit finder: reports whether any bit is set, its index and a one-hot copy.
module arb_ffs_lsb #(
  parameter int unsigned N = 4,
  localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   vec,
  output logic           found,
  output logic [IDW-1:0] idx,
  output logic [N-1:0]   onehot
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (vec[i-1]) begin
        found       = 1'b1;
        idx         = IDW'(i - 1);
        onehot      = '0;
        onehot[i-1] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb_hold.sv
// N-client round-robin arbiter with registered grant, optionally held until grant_ack.
module rr_arb_hold
  import rr_arb_hold_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter bit          WAIT_ACK = 1'b1,
  localparam int unsigned IDW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           block_arb,
  input  logic           grant_ack,
  output logic           grant_valid,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id
);

  localparam grant_mode_e MODE = WAIT_ACK ? GRANT_HOLD : GRANT_PULSE;

  logic [IDW-1:0] last_idx;
  logic [N-1:0]   mask;
  logic [N-1:0]   mreq;

  logic           m_found, r_found, win_found;
  logic [IDW-1:0] m_idx, r_idx, win_idx;
  logic [N-1:0]   m_oh, r_oh, win_oh;

  logic           may_issue;
  logic           holding;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      mask[i] = (i > 32'(last_idx));
    end
  end

  assign mreq = req & mask;

  arb_ffs_lsb #(.N(N)) u_ffs_masked (
    .vec    (mreq),
    .found  (m_found),
    .idx    (m_idx),
    .onehot (m_oh)
  );

  arb_ffs_lsb #(.N(N)) u_ffs_raw (
    .vec    (req),
    .found  (r_found),
    .idx    (r_idx),
    .onehot (r_oh)
  );

  // Masked search has priority; the raw search only matters on wrap-around.
  assign win_found = m_found | r_found;
  assign win_idx   = m_found ? m_idx : r_idx;
  assign win_oh    = m_found ? m_oh  : r_oh;

  assign holding   = (MODE == GRANT_HOLD) & grant_valid & ~grant_ack;
  assign may_issue = (MODE == GRANT_HOLD) ? ((~grant_valid | grant_ack) & ~block_arb)
                                          : ~block_arb;

  // When not issuing, anything other than an unacked held grant is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_valid <= 1'b0;
      grant       <= '0;
      grant_id    <= '0;
      last_idx    <= IDW'(N - 1);
    end else if (may_issue) begin
      if (win_found) begin
        grant_valid <= 1'b1;
        grant       <= win_oh;
        grant_id    <= win_idx;
        last_idx    <= win_idx;
      end else begin
        grant_valid <= 1'b0;
        grant       <= '0;
      end
    end else if (!holding) begin
      grant_valid <= 1'b0;
      grant       <= '0;
    end
  end

endmodule

// File: tb/tb_rr_arb_hold.sv
// Scoreboard bench for rr_arb_hold: one held-grant instance and one pulse-mode instance.
module tb_rr_arb_hold;

  typedef struct {
    bit         dut;
    logic       v;
    logic [3:0] g;
    logic [1:0] id;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req0 = '0, req1 = '0;
  logic       blk0 = 1'b0, blk1 = 1'b0;
  logic       ack0 = 1'b0, ack1 = 1'b0;
  logic       gv0, gv1;
  logic [3:0] g0, g1;
  logic [1:0] id0, id1;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rr_arb_hold #(.N(4), .WAIT_ACK(1'b1)) u_hold (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req0),
    .block_arb   (blk0),
    .grant_ack   (ack0),
    .grant_valid (gv0),
    .grant       (g0),
    .grant_id    (id0)
  );

  rr_arb_hold #(.N(4), .WAIT_ACK(1'b0)) u_pulse (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req1),
    .block_arb   (blk1),
    .grant_ack   (ack1),
    .grant_valid (gv1),
    .grant       (g1),
    .grant_id    (id1)
  );

  // Monitor: compares the outputs produced by the previous step's inputs.
  initial begin
    exp_t       e;
    logic       av;
    logic [3:0] ag;
    logic [1:0] aid;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        av  = e.dut ? gv1 : gv0;
        ag  = e.dut ? g1  : g0;
        aid = e.dut ? id1 : id0;
        checks++;
        if (av !== e.v || ag !== e.g || aid !== e.id) begin
          errors++;
          $display("FAIL %s: got valid=%b grant=%b id=%0d, want valid=%b grant=%b id=%0d",
                   e.name, av, ag, aid, e.v, e.g, e.id);
        end
      end
    end
  end

  task automatic step(input string nm, input bit d, input logic [3:0] r, input bit b,
                      input bit a, input bit rl, input logic ev, input logic [3:0] eg,
                      input logic [1:0] eid, input bit mid_rst = 1'b0);
    exp_t e;
    @(negedge clk);
    #1;
    rst_n = rl;
    if (d) begin
      req1 = r; blk1 = b; ack1 = a;
    end else begin
      req0 = r; blk0 = b; ack0 = a;
    end
    e.dut = d; e.v = ev; e.g = eg; e.id = eid; e.name = nm;
    q.push_back(e);
    if (mid_rst) begin
      @(posedge clk);
      #1;
      rst_n = 1'b0;
    end
  endtask

  initial begin
    // name, dut, req, block, ack, rst_n, exp valid, exp grant, exp id
    step("reset",     0, 4'b0000, 0, 0, 0, 1'b0, 4'b0000, 2'd0);
    // rotation with ack tied high
    step("rot0",      0, 4'b1111, 0, 1, 1, 1'b1, 4'b0001, 2'd0);
    step("rot1",      0, 4'b1111, 0, 1, 1, 1'b1, 4'b0010, 2'd1);
    step("rot2",      0, 4'b1111, 0, 1, 1, 1'b1, 4'b0100, 2'd2);
    step("rot3",      0, 4'b1111, 0, 1, 1, 1'b1, 4'b1000, 2'd3);
    step("rot4",      0, 4'b1111, 0, 1, 1, 1'b1, 4'b0001, 2'd0);
    step("rot5",      0, 4'b1111, 0, 1, 1, 1'b1, 4'b0010, 2'd1);
    // hold while req toggles
    step("hold_a",    0, 4'b1111, 0, 0, 1, 1'b1, 4'b0010, 2'd1);
    step("hold_b",    0, 4'b0000, 0, 0, 1, 1'b1, 4'b0010, 2'd1);
    step("hold_c",    0, 4'b1111, 0, 0, 1, 1'b1, 4'b0010, 2'd1);
    step("hold_d",    0, 4'b0000, 0, 0, 1, 1'b1, 4'b0010, 2'd1);
    step("hold_e",    0, 4'b1111, 0, 0, 1, 1'b1, 4'b0010, 2'd1);
    step("ack_1001",  0, 4'b1001, 0, 1, 1, 1'b1, 4'b1000, 2'd3);
    // wrap and mask
    step("wrap_0110", 0, 4'b0110, 0, 1, 1, 1'b1, 4'b0010, 2'd1);
    step("mask_0101", 0, 4'b0101, 0, 1, 1, 1'b1, 4'b0100, 2'd2);
    step("drain",     0, 4'b0000, 0, 1, 1, 1'b0, 4'b0000, 2'd2);
    // block_arb
    step("blk_a",     0, 4'b0100, 1, 0, 1, 1'b0, 4'b0000, 2'd2);
    step("blk_b",     0, 4'b0100, 1, 0, 1, 1'b0, 4'b0000, 2'd2);
    step("blk_c",     0, 4'b0100, 1, 0, 1, 1'b0, 4'b0000, 2'd2);
    step("unblk",     0, 4'b0100, 0, 0, 1, 1'b1, 4'b0100, 2'd2);
    step("blk_held",  0, 4'b1111, 1, 0, 1, 1'b1, 4'b0100, 2'd2);
    step("ack_blk",   0, 4'b1111, 1, 1, 1, 1'b0, 4'b0000, 2'd2);
    step("next_3",    0, 4'b1111, 0, 0, 1, 1'b1, 4'b1000, 2'd3);
    step("drop_req",  0, 4'b0000, 0, 0, 1, 1'b1, 4'b1000, 2'd3);
    // reset mid-hold, asserted between clock edges
    step("rst_async", 0, 4'b1111, 0, 0, 1, 1'b0, 4'b0000, 2'd0, 1'b1);
    step("post_rst",  0, 4'b1111, 0, 0, 1, 1'b1, 4'b0001, 2'd0);
    // pulse mode
    step("p_single0", 1, 4'b0100, 0, 0, 1, 1'b1, 4'b0100, 2'd2);
    step("p_single1", 1, 4'b0100, 0, 0, 1, 1'b1, 4'b0100, 2'd2);
    step("p_ackign",  1, 4'b0100, 0, 1, 1, 1'b1, 4'b0100, 2'd2);
    step("p_alt0",    1, 4'b1100, 0, 0, 1, 1'b1, 4'b1000, 2'd3);
    step("p_alt1",    1, 4'b1100, 0, 1, 1, 1'b1, 4'b0100, 2'd2);
    step("p_alt2",    1, 4'b1100, 0, 0, 1, 1'b1, 4'b1000, 2'd3);
    step("p_alt3",    1, 4'b1100, 0, 1, 1, 1'b1, 4'b0100, 2'd2);
    step("p_idle",    1, 4'b0000, 0, 0, 1, 1'b0, 4'b0000, 2'd2);
    step("p_blk",     1, 4'b0100, 1, 0, 1, 1'b0, 4'b0000, 2'd2);
    step("p_unblk",   1, 4'b0100, 0, 0, 1, 1'b1, 4'b0100, 2'd2);

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses never compared, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
